// File: rtl/sudoku_pkg.sv
// Shared constants and types for the Sudoku board RAM arbiter.
package sudoku_pkg;

    localparam int CELLS   = 81;
    localparam int ADDR_W  = 7;
    localparam int VAL_W   = 4;
    localparam int WAIT_W  = 4;
    localparam int NUM_REQ = 3;

    localparam logic [WAIT_W-1:0] WAIT_MAX   = 4'd15;
    localparam logic [ADDR_W-1:0] CELL_LIMIT = ADDR_W'(CELLS);

    typedef enum logic [1:0] {
        REQ_SOLV = 2'd0,
        REQ_ENT  = 2'd1,
        REQ_DISP = 2'd2
    } req_id_t;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } arb_state_t;

    function automatic logic addr_in_range(input logic [ADDR_W-1:0] addr);
        return addr < CELL_LIMIT;
    endfunction

endpackage

// File: rtl/sudoku_arb_pick.sv
// Combinational winner select: solver lock first, then display starvation override,
// then fixed priority solver > entry > display. Output is one-hot (or all zero).
module sudoku_arb_pick
    import sudoku_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  logic               lock,
    input  logic               starve,
    output logic [NUM_REQ-1:0] winner
);

    always_comb begin
        // NOTE: default assignment first so every path drives winner and no latch is inferred.
        winner = '0;
        if (lock) begin
            winner[REQ_SOLV] = req[REQ_SOLV];
        end else if (starve && req[REQ_DISP]) begin
            winner[REQ_DISP] = 1'b1;
        end else if (req[REQ_SOLV]) begin
            winner[REQ_SOLV] = 1'b1;
        end else if (req[REQ_ENT]) begin
            winner[REQ_ENT] = 1'b1;
        end else if (req[REQ_DISP]) begin
            winner[REQ_DISP] = 1'b1;
        end
    end

endmodule

// File: rtl/sudoku_board_arbiter.sv
// Shares the single-port Sudoku board RAM among solver, cell entry and display readback.
// One grant per two cycles; read data returns the cycle after the grant.
module sudoku_board_arbiter
    import sudoku_pkg::*;
(
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic              Solv_Req,
    input  logic              Solv_We,
    input  logic              Solv_Lock,
    input  logic [ADDR_W-1:0] Solv_Addr,
    input  logic [VAL_W-1:0]  Solv_WData,
    output logic              Solv_Gnt,
    output logic              Solv_RValid,
    input  logic              Ent_Req,
    input  logic [ADDR_W-1:0] Ent_Addr,
    input  logic [VAL_W-1:0]  Ent_WData,
    output logic              Ent_Gnt,
    input  logic              Disp_Req,
    input  logic [ADDR_W-1:0] Disp_Addr,
    output logic              Disp_Gnt,
    output logic              Disp_RValid,
    output logic [VAL_W-1:0]  RData,
    output logic              Addr_Err,
    output logic              RAM_En,
    output logic              RAM_We,
    output logic [ADDR_W-1:0] RAM_Addr,
    output logic [VAL_W-1:0]  RAM_WData,
    input  logic [VAL_W-1:0]  RAM_RData
);

    arb_state_t          state_q;
    logic [WAIT_W-1:0]   wait_cnt_q;
    logic                lock_q;
    logic                gnt_we_q;
    logic                rd_zero_q;
    logic [NUM_REQ-1:0]  req_vec;
    logic [NUM_REQ-1:0]  winner;
    logic                starve;
    logic [ADDR_W-1:0]   win_addr;
    logic [VAL_W-1:0]    win_wdata;
    logic                win_we;
    logic                win_ok;
    logic                take;

    always_comb begin
        req_vec           = '0;
        req_vec[REQ_SOLV] = Solv_Req;
        req_vec[REQ_ENT]  = Ent_Req;
        req_vec[REQ_DISP] = Disp_Req;
    end

    assign starve = (wait_cnt_q == WAIT_MAX);

    sudoku_arb_pick u_pick (
        .req    (req_vec),
        .lock   (lock_q),
        .starve (starve),
        .winner (winner)
    );

    always_comb begin
        win_addr  = Disp_Addr;
        win_wdata = '0;
        win_we    = 1'b0;
        if (winner[REQ_SOLV]) begin
            win_addr  = Solv_Addr;
            win_wdata = Solv_WData;
            win_we    = Solv_We;
        end else if (winner[REQ_ENT]) begin
            win_addr  = Ent_Addr;
            win_wdata = Ent_WData;
            win_we    = 1'b1;
        end
    end

    assign win_ok = addr_in_range(win_addr);
    assign take   = (state_q == ST_IDLE) && (winner != '0);

    // Grant cycle outputs are registered from the winner; the read pipe follows one cycle later.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q     <= ST_IDLE;
            Solv_Gnt    <= 1'b0;
            Ent_Gnt     <= 1'b0;
            Disp_Gnt    <= 1'b0;
            Addr_Err    <= 1'b0;
            RAM_En      <= 1'b0;
            RAM_We      <= 1'b0;
            RAM_Addr    <= '0;
            RAM_WData   <= '0;
            gnt_we_q    <= 1'b0;
            Solv_RValid <= 1'b0;
            Disp_RValid <= 1'b0;
            rd_zero_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking so every register samples the pre-edge values of its peers.
            state_q     <= take ? ST_GRANT : ST_IDLE;
            Solv_Gnt    <= take && winner[REQ_SOLV];
            Ent_Gnt     <= take && winner[REQ_ENT];
            Disp_Gnt    <= take && winner[REQ_DISP];
            Addr_Err    <= take && !win_ok;
            RAM_En      <= take && win_ok;
            RAM_We      <= take && win_ok && win_we;
            RAM_Addr    <= take ? win_addr : '0;
            RAM_WData   <= take ? win_wdata : '0;
            gnt_we_q    <= take && win_we;
            Solv_RValid <= Solv_Gnt && !gnt_we_q;
            Disp_RValid <= Disp_Gnt;
            rd_zero_q   <= Addr_Err;
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            wait_cnt_q <= '0;
            lock_q     <= 1'b0;
        end else begin
            if (!Disp_Req || Disp_Gnt) begin
                wait_cnt_q <= '0;
            end else if (wait_cnt_q != WAIT_MAX) begin
                wait_cnt_q <= wait_cnt_q + 1'b1;
            end

            if (Solv_Gnt && Solv_Lock) begin
                lock_q <= 1'b1;
            end else if (state_q == ST_IDLE && !Solv_Lock) begin
                lock_q <= 1'b0;
            end
        end
    end

    // Out-of-range reads never touched the RAM, so they return zero.
    assign RData = ((Solv_RValid || Disp_RValid) && !rd_zero_q) ? RAM_RData : '0;

endmodule
